// File: rtl/ram_io_responder_if.sv
// ram_io_responder_if
//   Groups the controller byte bus and the two host streams seen by
//   ram_io_responder.
//   Controller bus : addr_i, wr_i, din_i -> responder ; dout_o <- responder
//   TX stream      : tx_data, tx_valid <- responder ; tx_ready -> responder
//   RX stream      : rx_data, rx_valid -> responder ; rx_ready <- responder
//   Status         : overflow <- responder (sticky TX drop flag)
//   master = controller/host side, slave = responder side.
interface ram_io_responder_if;
  logic [31:0] addr_i;
  logic        wr_i;
  logic [7:0]  din_i;
  logic [7:0]  dout_o;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        overflow;

  modport master (
    output addr_i, wr_i, din_i, tx_ready, rx_data, rx_valid,
    input  dout_o, tx_data, tx_valid, rx_ready, overflow
  );

  modport slave (
    input  addr_i, wr_i, din_i, tx_ready, rx_data, rx_valid,
    output dout_o, tx_data, tx_valid, rx_ready, overflow
  );
endinterface

// File: rtl/ram_io_responder.sv
// ram_io_responder
//   Responder for the byte-wide RAM bus of the CPU memory controller.
//   Addresses below IO_BASE hit a synchronous on-chip RAM (1-cycle read
//   latency). At IO_BASE an I/O window exposes:
//     IO_BASE+0 write : push byte into the TX FIFO (drop + sticky overflow when full)
//     IO_BASE+0 read  : RX holding byte (00 if empty); consumed on the first
//                       cycle of a read run only
//     IO_BASE+4 read  : {6'b0, rx_full, tx_full}
//     IO_BASE+4 write : clear overflow
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : ram_io_responder_if.slave (controller bus + host streams)
module ram_io_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_BASE    = 32'h00030000,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_io_responder_if.slave bus
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(TX_DEPTH);

  logic [7:0]    r_mem [0:(1 << ADDR_WIDTH) - 1];
  logic [7:0]    r_tx_buf [TX_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_rx_full;
  logic [7:0]    r_rx_data;
  logic          r_prev_valid;
  logic          r_prev_rx_read;
  logic          r_overflow;
  logic [7:0]    r_dout;

  logic                  w_io;
  logic                  w_data_addr;
  logic                  w_stat_addr;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_tx_full;
  logic                  w_tx_pop;
  logic                  w_tx_push;
  logic                  w_tx_drop;
  logic                  w_rx_read;
  logic                  w_rx_pop;
  logic                  w_rx_load;

  assign w_io        = (bus.addr_i >= IO_BASE);
  assign w_data_addr = (bus.addr_i == IO_BASE);
  assign w_stat_addr = (bus.addr_i == IO_BASE + 32'd4);
  assign w_idx       = bus.addr_i[ADDR_WIDTH-1:0];

  assign w_tx_full = (r_count == FULL_COUNT);
  assign w_tx_pop  = (r_count != '0) && bus.tx_ready;
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign w_tx_push = bus.wr_i && w_data_addr && (!w_tx_full || w_tx_pop);
  assign w_tx_drop = bus.wr_i && w_data_addr && w_tx_full && !w_tx_pop;

  // Only the first cycle of a run of reads at IO_BASE+0 consumes the byte,
  // so a controller stalled on the address does not eat several bytes.
  assign w_rx_read = !bus.wr_i && w_data_addr;
  assign w_rx_pop  = w_rx_read && !(r_prev_valid && r_prev_rx_read) && r_rx_full;
  assign w_rx_load = bus.rx_valid && !r_rx_full;

  always_ff @(posedge clk) begin
    if (bus.wr_i && !w_io) begin
      r_mem[w_idx] <= bus.din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < TX_DEPTH; i++) begin
        r_tx_buf[i] <= '0;
      end
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rx_full      <= 1'b0;
      r_rx_data      <= '0;
      r_prev_valid   <= 1'b0;
      r_prev_rx_read <= 1'b0;
      r_overflow     <= 1'b0;
      r_dout         <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_buf[r_wr_ptr] <= bus.din_i;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_tx_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (w_tx_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.wr_i && w_stat_addr) begin
        r_overflow <= 1'b0;
      end

      // Pop requires full and load requires empty, so at most one fires;
      // a load blocked by the pop is taken on the following edge.
      if (w_rx_pop) begin
        r_rx_full <= 1'b0;
      end else if (w_rx_load) begin
        r_rx_full <= 1'b1;
        r_rx_data <= bus.rx_data;
      end

      r_prev_valid   <= 1'b1;
      r_prev_rx_read <= w_rx_read;

      if (!bus.wr_i) begin
        if (!w_io) begin
          r_dout <= r_mem[w_idx];
        end else if (w_data_addr) begin
          r_dout <= r_rx_full ? r_rx_data : '0;
        end else if (w_stat_addr) begin
          r_dout <= {6'b0, r_rx_full, w_tx_full};
        end else begin
          r_dout <= '0;
        end
      end
    end
  end

  assign bus.dout_o   = r_dout;
  assign bus.tx_data  = r_tx_buf[r_rd_ptr];
  assign bus.tx_valid = (r_count != '0);
  assign bus.rx_ready = !r_rx_full;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_ram_io_responder.sv
module tb_ram_io_responder;
  localparam logic [31:0] IO_BASE = 32'h00030000;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_io_responder_if bus();

  ram_io_responder #(
    .ADDR_WIDTH(17),
    .IO_BASE(IO_BASE),
    .TX_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: RAM as a sparse array, TX FIFO as a queue,
  // RX holding register as a byte plus full flag.
  logic [7:0] m_mem [int];
  logic [7:0] m_txq [$];
  bit         m_rx_full;
  logic [7:0] m_rx;
  bit         m_ovf;
  logic [7:0] m_dout;
  bit         m_dout_known;
  bit         m_prev_rd;

  always @(posedge clk or posedge rst) begin
    logic [31:0] a;
    int          idx;
    bit          pop;
    bit          was_full;
    bit          rx_was_full;
    if (rst) begin
      m_txq.delete();
      m_rx_full    = 0;
      m_rx         = 8'h00;
      m_ovf        = 0;
      m_dout       = 8'h00;
      m_dout_known = 1;
      m_prev_rd    = 0;
    end else begin
      a           = bus.addr_i;
      idx         = int'(a[16:0]);
      was_full    = (m_txq.size() == DEPTH);
      rx_was_full = m_rx_full;
      pop         = (m_txq.size() != 0) && bus.tx_ready;
      if (pop) void'(m_txq.pop_front());
      if (bus.wr_i) begin
        if (a < IO_BASE) m_mem[idx] = bus.din_i;
        else if (a == IO_BASE) begin
          if (!was_full || pop) m_txq.push_back(bus.din_i);
          else m_ovf = 1;
        end else if (a == IO_BASE + 4) m_ovf = 0;
      end else begin
        m_dout_known = 1;
        if (a < IO_BASE) begin
          if (m_mem.exists(idx)) m_dout = m_mem[idx];
          else m_dout_known = 0;
        end else if (a == IO_BASE) begin
          m_dout = rx_was_full ? m_rx : 8'h00;
          if (!m_prev_rd) m_rx_full = 0;
        end else if (a == IO_BASE + 4) begin
          m_dout = {6'b0, rx_was_full, was_full};
        end else m_dout = 8'h00;
      end
      if (!rx_was_full && bus.rx_valid) begin
        m_rx_full = 1;
        m_rx      = bus.rx_data;
      end
      m_prev_rd = !bus.wr_i && (a == IO_BASE);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_dout_known) chk("dout", bus.dout_o, m_dout);
      chk("tx_valid", {7'b0, bus.tx_valid}, {7'b0, m_txq.size() != 0});
      if (m_txq.size() != 0) chk("tx_data", bus.tx_data, m_txq[0]);
      chk("rx_ready", {7'b0, bus.rx_ready}, {7'b0, !m_rx_full});
      chk("overflow", {7'b0, bus.overflow}, {7'b0, m_ovf});
    end
  end

  task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d);
    bus.addr_i = a;
    bus.wr_i   = w;
    bus.din_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(IO_BASE + 32'd8, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] ra;
    logic        rw;
    bus.addr_i   = IO_BASE + 32'd8;
    bus.wr_i     = 1'b0;
    bus.din_i    = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", bus.dout_o, 8'h00);
    chk("rst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    chk("rst_overflow", {7'b0, bus.overflow}, 8'h00);
    rst = 1'b0;

    // RAM latency and 17-bit indexing
    cyc(32'h00010, 1'b1, 8'hA5);
    cyc(32'h00010, 1'b0, 8'h00);
    chk("ram_rd_a5", bus.dout_o, 8'hA5);
    cyc(32'h10010, 1'b1, 8'h5A);
    chk("ram_wr_holds", bus.dout_o, 8'hA5);
    cyc(32'h10010, 1'b0, 8'h00);
    chk("ram_rd_hi", bus.dout_o, 8'h5A);
    cyc(32'h00010, 1'b0, 8'h00);
    chk("ram_rd_lo", bus.dout_o, 8'hA5);

    // TX path
    cyc(IO_BASE, 1'b1, 8'h48);
    chk("tx_valid_rise", {7'b0, bus.tx_valid}, 8'h01);
    idle();
    cyc(IO_BASE, 1'b1, 8'h69);
    idle();
    chk("tx_head_H", bus.tx_data, 8'h48);
    bus.tx_ready = 1'b1;
    idle();
    chk("tx_head_i", bus.tx_data, 8'h69);
    idle();
    chk("tx_drained", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // TX overflow
    for (int i = 0; i < 9; i++) begin
      cyc(IO_BASE, 1'b1, 8'h30 + 8'(i));
      idle();
    end
    chk("ovf_set", {7'b0, bus.overflow}, 8'h01);
    chk("ovf_head", bus.tx_data, 8'h30);
    cyc(IO_BASE + 32'd4, 1'b0, 8'h00);
    chk("status_full", bus.dout_o, 8'h01);
    cyc(IO_BASE + 32'd4, 1'b1, 8'h00);
    chk("ovf_clear", {7'b0, bus.overflow}, 8'h00);
    bus.tx_ready = 1'b1;
    cyc(IO_BASE, 1'b1, 8'h77);
    chk("full_push_pop_ovf", {7'b0, bus.overflow}, 8'h00);
    chk("full_push_pop_head", bus.tx_data, 8'h31);
    repeat (8) idle();
    chk("ovf_drained", {7'b0, bus.tx_valid}, 8'h00);
    bus.tx_ready = 1'b0;

    // RX edge detect
    bus.rx_data  = 8'h41;
    bus.rx_valid = 1'b1;
    idle();
    chk("rx_loaded", {7'b0, bus.rx_ready}, 8'h00);
    bus.rx_valid = 1'b0;
    cyc(IO_BASE, 1'b0, 8'h00);
    chk("rx_rd1", bus.dout_o, 8'h41);
    chk("rx_ready_after", {7'b0, bus.rx_ready}, 8'h01);
    cyc(IO_BASE, 1'b0, 8'h00);
    chk("rx_rd2", bus.dout_o, 8'h00);
    cyc(IO_BASE, 1'b0, 8'h00);
    chk("rx_rd3", bus.dout_o, 8'h00);
    idle();
    cyc(IO_BASE, 1'b0, 8'h00);
    chk("rx_rd_empty", bus.dout_o, 8'h00);

    // RX status and back-to-back
    bus.rx_data  = 8'h42;
    bus.rx_valid = 1'b1;
    idle();
    bus.rx_data  = 8'h43;
    cyc(IO_BASE + 32'd4, 1'b0, 8'h00);
    chk("status_rx", bus.dout_o, 8'h02);
    cyc(IO_BASE, 1'b0, 8'h00);
    chk("rx_b2b_42", bus.dout_o, 8'h42);
    chk("rx_pop_empty", {7'b0, bus.rx_ready}, 8'h01);
    idle();
    chk("rx_reload", {7'b0, bus.rx_ready}, 8'h00);
    bus.rx_valid = 1'b0;
    cyc(IO_BASE, 1'b0, 8'h00);
    chk("rx_b2b_43", bus.dout_o, 8'h43);

    // Async reset mid-drain
    for (int i = 0; i < 4; i++) begin
      cyc(IO_BASE, 1'b1, 8'h60 + 8'(i));
      idle();
    end
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    idle();
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    cyc(32'h00010, 1'b0, 8'h00);
    chk("pre_rst_dout", bus.dout_o, 8'hA5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
    chk("arst_rx_ready", {7'b0, bus.rx_ready}, 8'h01);
    chk("arst_overflow", {7'b0, bus.overflow}, 8'h00);
    chk("arst_dout", bus.dout_o, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the model
    ra = 32'h0;
    rw = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      bus.tx_ready = ($urandom_range(0, 2) != 0);
      bus.rx_valid = ($urandom_range(0, 2) == 0);
      bus.rx_data  = 8'($urandom);
      if ($urandom_range(0, 9) >= 3) begin
        case ($urandom_range(0, 9))
          0, 1, 2: ra = 32'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 32'h10000 : 32'h0);
          3, 4:    ra = IO_BASE;
          5:       ra = IO_BASE + 32'd4;
          6:       ra = IO_BASE + 32'd8;
          7:       ra = 32'hFFFF_FFF0;
          8:       ra = 32'h0002_FFFF;
          default: ra = 32'h0000_FFFF;
        endcase
        rw = ($urandom_range(0, 1) != 0);
      end
      cyc(ra, rw, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the byte-wide RAM bus driven by the CPU memory controller (address, write-enable, write byte out; read byte back).
- Serves a synchronous on-chip RAM below IO_BASE and a small memory-mapped I/O window at IO_BASE.
- The I/O window holds a TX byte FIFO that drains to a host stream, and a single-entry RX holding register fed from a host stream.
- Sits between the memory controller and the top-level RAM/host pins.

Parameters:
- ADDR_WIDTH, 17, RAM index bits; RAM size is 2^ADDR_WIDTH bytes.
- IO_BASE, 32'h00030000, base of the I/O window.
- TX_DEPTH, 8, TX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- addr_i  in  32  byte address from controller
- wr_i  in  1  1 = write din_i this cycle, 0 = read
- din_i  in  8  write byte from controller
- dout_o  out  8  read byte to controller
- tx_data  out  8  head of TX FIFO
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  host accepts tx_data
- rx_data  in  8  host byte
- rx_valid  in  1  host offers rx_data
- rx_ready  out  1  RX holding register empty
- overflow  out  1  sticky: TX push while full

Behaviour:
- Reset is asynchronous and active-high on rst; the block uses one clock, clk.
- Reset values: dout_o=0, tx_valid=0, tx_data=0, rx_ready=1, overflow=0. FIFO pointers and count are cleared, the RX register is empty, and the previous-access tracker is cleared. RAM contents are not reset.
- Reset asserted mid-operation discards all queued TX/RX bytes immediately, with no clock edge needed.
- Address decode: io = (addr_i >= IO_BASE). When io=0, RAM is indexed by addr_i[ADDR_WIDTH-1:0].
- RAM read: dout_o is registered at the rising edge that samples addr_i and holds until the next read edge. Latency is 1 cycle, so data is valid through the cycle after the address is presented.
- RAM write: on the edge with wr_i=1, mem[idx] <= din_i. During a write cycle dout_o holds its previous value. Repeated writes of the same byte on consecutive cycles are harmless.
- IO_BASE+0, write: push din_i into the TX FIFO on every edge with wr_i=1. The controller deasserts wr_i between distinct I/O stores.
- IO_BASE+0, push when full: the byte is dropped and overflow is set to 1 (sticky).
- IO_BASE+0, read: dout_o <= RX byte if the RX register is full, else 8'h00.
- IO_BASE+0, pop: the RX register empties only on the first cycle of a read run. A run is consecutive read cycles at IO_BASE+0. A stalled controller that holds the address therefore consumes one byte only.
- IO_BASE+4, read: dout_o <= {6'b0, rx_full, tx_full}.
- IO_BASE+4, write: clears overflow.
- Any other I/O address: reads return 8'h00 and writes are ignored.
- TX FIFO: circular buffer with wrap-around read/write pointers and a 0..TX_DEPTH count.
  - tx_data always shows the head entry; tx_valid = (count != 0).
  - A pop happens on an edge with tx_valid && tx_ready.
  - Simultaneous push and pop: count is unchanged. When full, the push succeeds if a pop happens on the same edge, and overflow is not set.
  - Push when empty: tx_valid rises on the following cycle (no bypass).
- RX register: loads rx_data on an edge with rx_valid && rx_ready; rx_ready = !rx_full.
  - Pop and load on the same edge: the pop wins that edge, the register becomes empty, and the load happens on the next edge (rx_ready=0 in the pop cycle).
- No internal state machine beyond the FIFO counters and the previous-access register {valid, was_rx_read}.

Test Plan:
- RAM latency: write 8'hA5 to 0x00010; read 0x00010 → dout_o=8'hA5 in the cycle after the address. Read 0x10010 with ADDR_WIDTH=17 → returns mem[0x10010].
- TX path: push 'H','i' with tx_ready=0 → tx_valid=1, tx_data=8'h48. Raise tx_ready → 8'h48 then 8'h69 are drained, then tx_valid=0.
- TX overflow: 9 pushes with tx_ready=0 → 9th byte dropped, overflow=1, status read=8'h01. Write IO_BASE+4 → overflow=0. Full push with a simultaneous pop → no overflow.
- RX edge-detect: host offers 8'h41; read IO_BASE+0 held for 3 cycles → dout_o=8'h41 once, one byte consumed, rx_ready=1 after. A further read returns 8'h00.
- RX status and back-to-back: rx_valid held with 8'h42 then 8'h43 → status=8'h02. Pop → next byte loaded one edge later.
- Async reset: assert rst mid-drain with 3 bytes queued, no clk edge → tx_valid=0, rx_ready=1, overflow=0, dout_o=0 immediately.
